// File: rtl/hsync_sequencer.sv
// Horizontal line timing for the TIA: /4 colour-clock phase, 57-count line, HBLANK/HSYNC/CBURST latches, RSYNC/WSYNC/HMOVE.
// Optional colour burst generation is enabled by defining TIA_HSYNC_CBURST_EN; otherwise cburst is tied low.
module hsync_sequencer #(
  parameter int LINE_COUNTS     = 57,
  parameter int HSYNC_SET       = 4,
  parameter int HSYNC_RST       = 8,
  parameter int CBURST_SET      = 8,
  parameter int CBURST_RST      = 12,
  parameter int HBLANK_RST      = 17,
  parameter int HBLANK_LATE_RST = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rsync,
  input  logic       wsync,
  input  logic       hmove,
  output logic [5:0] hcount,
  output logic [1:0] phase,
  output logic       line_start,
  output logic       hblank,
  output logic       hsync,
  output logic       cburst,
  output logic       rdy
);

  localparam logic [5:0] LAST_CNT   = 6'(LINE_COUNTS - 1);
  localparam logic [5:0] HS_SET_CNT = 6'(HSYNC_SET);
  localparam logic [5:0] HS_RST_CNT = 6'(HSYNC_RST);
  localparam logic [5:0] HB_RST_CNT = 6'(HBLANK_RST);
  localparam logic [5:0] HB_LATE_CNT = 6'(HBLANK_LATE_RST);

  // Elaboration-time guard on the timing parameters.
  if (!((HSYNC_SET > 0) && (HSYNC_SET < HSYNC_RST) && (HSYNC_RST < LINE_COUNTS) &&
        (CBURST_SET < CBURST_RST) &&
        (HBLANK_RST < HBLANK_LATE_RST) && (HBLANK_LATE_RST < LINE_COUNTS) &&
        (LINE_COUNTS <= 64))) begin : g_bad_params
    $error("hsync_sequencer: illegal timing parameters");
  end

  logic       hmove_latch;
  logic       wrap;
  logic       lstart;
  logic       cnt_step;
  logic [5:0] nxt_count;

  always_comb begin
    wrap      = (hcount == LAST_CNT) && (phase == 2'd3);
    lstart    = rsync || wrap;
    // Event decode happens only on edges that advance hcount within the line.
    cnt_step  = (phase == 2'd3) && !lstart;
    nxt_count = hcount + 6'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount      <= 6'd0;
      phase       <= 2'd0;
      line_start  <= 1'b0;
      hblank      <= 1'b1;
      hsync       <= 1'b0;
      hmove_latch <= 1'b0;
      rdy         <= 1'b1;
    end else begin
      phase      <= rsync ? 2'd0 : phase + 2'd1;
      line_start <= lstart;
      rdy        <= wsync ? 1'b0 : (lstart ? 1'b1 : rdy);
      if (lstart) begin
        hcount      <= 6'd0;
        hblank      <= 1'b1;
        hsync       <= 1'b0;
        hmove_latch <= 1'b0;
      end else begin
        if (hmove) hmove_latch <= 1'b1;
        if (cnt_step) begin
          hcount <= nxt_count;
          if (nxt_count == HS_SET_CNT)
            hsync <= 1'b1;
          else if (nxt_count == HS_RST_CNT)
            hsync <= 1'b0;
          // The latch value from before this edge decides; a same-edge hmove is too late.
          if ((nxt_count == HB_RST_CNT) && !hmove_latch)
            hblank <= 1'b0;
          if (nxt_count == HB_LATE_CNT)
            hblank <= 1'b0;
        end
      end
    end
  end

`ifdef TIA_HSYNC_CBURST_EN
  localparam logic [5:0] CB_SET_CNT = 6'(CBURST_SET);
  localparam logic [5:0] CB_RST_CNT = 6'(CBURST_RST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cburst <= 1'b0;
    end else if (lstart) begin
      cburst <= 1'b0;
    end else if (cnt_step) begin
      if (nxt_count == CB_SET_CNT)
        cburst <= 1'b1;
      else if (nxt_count == CB_RST_CNT)
        cburst <= 1'b0;
    end
  end
`else
  assign cburst = 1'b0;
`endif

endmodule
